// File: rtl/step_grid_renderer.sv
// step_grid_renderer: scans the TRACKS x STEPS step grid and emits one registered VGA pixel write per clock
module step_grid_renderer #(
  parameter int STEPS = 16,
  parameter int TRACKS = 4,
  parameter int CELL_W = 32,
  parameter int CELL_H = 32,
  parameter int X0 = 64,
  parameter int Y0 = 112,
  parameter int COLOR_DEPTH = 9,
  parameter logic [COLOR_DEPTH-1:0] C_OFF = 9'o000,
  parameter logic [COLOR_DEPTH-1:0] C_ON = 9'o707,
  parameter logic [COLOR_DEPTH-1:0] C_PH_OFF = 9'o111,
  parameter logic [COLOR_DEPTH-1:0] C_PH_ON = 9'o770,
  parameter logic [COLOR_DEPTH-1:0] C_GRID = 9'o222
) (
  input  logic                       CLOCK_50,
  input  logic                       Resetn,
  input  logic [STEPS*TRACKS-1:0]    pattern,
  input  logic [$clog2(STEPS)-1:0]   playhead,
  input  logic                       redraw_req,
  output logic [9:0]                 VGA_X,
  output logic [8:0]                 VGA_Y,
  output logic [COLOR_DEPTH-1:0]     VGA_COLOR,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);
  localparam int PXW = $clog2(CELL_W);
  localparam int PYW = $clog2(CELL_H);
  localparam int CW = $clog2(STEPS);
  localparam int RW = $clog2(TRACKS);
  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;
  state_t state;
  logic [STEPS*TRACKS-1:0] snap_pat;
  logic [CW-1:0] snap_ph, col;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;
  logic [RW-1:0] row;
  logic pending, last_px, last_py, last_col, last_row, on, ph;
  logic [COLOR_DEPTH-1:0] color;
  always_comb begin
    last_px = px == PXW'(CELL_W - 1);
    last_py = py == PYW'(CELL_H - 1);
    last_col = col == CW'(STEPS - 1);
    last_row = row == RW'(TRACKS - 1);
    on = 1'(snap_pat >> (int'(row) * STEPS + int'(col)));
    ph = col == snap_ph;
    color = (last_px || last_py) ? C_GRID :
            (ph && on) ? C_PH_ON : ph ? C_PH_OFF : on ? C_ON : C_OFF;
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      snap_pat <= '0;
      snap_ph <= '0;
      pending <= 1'b1;
      px <= '0;
      py <= '0;
      col <= '0;
      row <= '0;
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      pending <= pending | redraw_req;
      case (state)
        IDLE: if (pending || redraw_req || pattern != snap_pat || playhead != snap_ph) state <= LOAD;
        LOAD: begin
          snap_pat <= pattern;
          snap_ph <= playhead;
          pending <= redraw_req;
          px <= '0;
          py <= '0;
          col <= '0;
          row <= '0;
          busy <= 1'b1;
          state <= DRAW;
        end
        DRAW: begin
          plot <= 1'b1;
          VGA_X <= 10'(X0 + CELL_W * int'(col) + int'(px));
          VGA_Y <= 9'(Y0 + CELL_H * int'(row) + int'(py));
          VGA_COLOR <= color;
          px <= last_px ? '0 : px + 1'b1;
          py <= !last_px ? py : last_py ? '0 : py + 1'b1;
          col <= !(last_px && last_py) ? col : last_col ? '0 : col + 1'b1;
          row <= !(last_px && last_py && last_col) ? row : last_row ? '0 : row + 1'b1;
          if (last_px && last_py && last_col && last_row) state <= DONE;
        end
        default: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_step_grid_renderer.sv
// tb_step_grid_renderer: scoreboard bench for the step grid renderer on a 4x2 grid of 4x4 cells
module tb_step_grid_renderer;
  logic CLOCK_50 = 1'b0;
  logic Resetn;
  logic [7:0] pattern;
  logic [1:0] playhead;
  logic redraw_req;
  logic [9:0] VGA_X;
  logic [8:0] VGA_Y;
  logic [8:0] VGA_COLOR;
  logic plot, busy, done;
  int vectors = 0, miscompares = 0, since = 0, done_cnt = 0;
  logic [27:0] q[$];
  logic [27:0] exp_px;
  logic any_plot, any_busy, any_done;

  step_grid_renderer #(.STEPS(4), .TRACKS(2), .CELL_W(4), .CELL_H(4), .X0(10), .Y0(20)) dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .pattern(pattern), .playhead(playhead),
    .redraw_req(redraw_req), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] model(logic [7:0] pat, int ph, int k);
    int px = k % 4, py = (k / 4) % 4, col = (k / 16) % 4, row = k / 64;
    logic on, h;
    logic [8:0] c;
    on = pat[row * 4 + col];
    h = col == ph;
    c = (px == 3 || py == 3) ? 9'o222 : (h && on) ? 9'o770 : h ? 9'o111 : on ? 9'o707 : 9'o000;
    return {10'(10 + col * 4 + px), 9'(20 + row * 4 + py), c};
  endfunction

  task automatic push_frame(input logic [7:0] pat, input int ph);
    for (int k = 0; k < 128; k++) q.push_back(model(pat, ph, k));
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_since(input int n);
    for (int i = 0; i < 1000 && since < n; i++) tick();
    chk("wait_plot", since >= n, 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 2000 && done_cnt < n; i++) tick();
    chk("wait_done", done_cnt >= n, 1);
    chk("queue_empty", q.size(), 0);
  endtask

  task automatic pulse_redraw();
    redraw_req = 1'b1;
    tick();
    redraw_req = 1'b0;
  endtask

  always @(negedge CLOCK_50) begin
    if (Resetn) begin
      if (plot) begin
        if (q.size() == 0) chk("extra_plot", 1, 0);
        else begin
          exp_px = q.pop_front();
          chk("pixel", {VGA_X, VGA_Y, VGA_COLOR}, exp_px);
        end
        since++;
      end
      if (done) begin
        chk("frame_len", since, 128);
        since = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    pattern = 8'h00;
    playhead = 2'd0;
    redraw_req = 1'b0;
    #1;
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", {VGA_X, VGA_Y, VGA_COLOR}, 0);
    push_frame(8'h00, 0);
    repeat (3) tick();
    Resetn = 1'b1;
    wait_done(1);
    // quiet period with unchanged inputs
    any_plot = 0; any_busy = 0; any_done = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      any_plot |= plot; any_busy |= busy; any_done |= done;
    end
    chk("idle_plot", any_plot, 0);
    chk("idle_busy", any_busy, 0);
    chk("idle_done", any_done, 0);
    chk("idle_done_cnt", done_cnt, 1);
    // new pattern/playhead, with trigger-to-first-plot latency
    pattern = 8'b0000_0010;
    playhead = 2'd3;
    push_frame(8'b0000_0010, 3);
    tick();
    chk("lat_load", plot, 0);
    tick();
    chk("lat_reg", plot, 0);
    tick();
    chk("lat_first", plot, 1);
    chk("busy_mid", busy, 1);
    wait_done(2);
    // pattern change in mid frame
    playhead = 2'd0;
    push_frame(8'b0000_0010, 0);
    wait_since(40);
    pattern = 8'hA5;
    push_frame(8'hA5, 0);
    chk("busy_frame", busy, 1);
    wait_done(4);
    // three redraw pulses collapse into one extra frame
    playhead = 2'd2;
    push_frame(8'hA5, 2);
    wait_since(10);
    pulse_redraw();
    push_frame(8'hA5, 2);
    wait_since(50);
    pulse_redraw();
    wait_since(90);
    pulse_redraw();
    wait_done(6);
    repeat (200) tick();
    chk("no_third_frame", done_cnt, 6);
    // reset in mid frame
    push_frame(8'hA5, 2);
    pulse_redraw();
    wait_since(70);
    Resetn = 1'b0;
    #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    since = 0;
    push_frame(8'hA5, 2);
    repeat (2) tick();
    Resetn = 1'b1;
    wait_done(7);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
